// File: rtl/mod_multiplier.sv
// Iterative modular multiplier: oData = (iA * iB) mod iQ using MSB-first
// interleaved double/add/reduce, one multiplier bit per clock edge.
// Optional build macro MOD_MULT_RADIX4_EN: two multiplier bits per edge
// (BITWIDTH must be even), halving the accept-to-result latency.
// Feeds mod_accumulator: oData -> iData, oValid && iReady -> iEn.
module mod_multiplier #(
   parameter int unsigned BITWIDTH = 32
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iValid,
   output logic                oReady,
   input  logic [BITWIDTH-1:0] iA,
   input  logic [BITWIDTH-1:0] iB,
   input  logic [BITWIDTH-1:0] iQ,
   output logic                oValid,
   input  logic                iReady,
   output logic [BITWIDTH-1:0] oData,
   output logic                oErr
);

   localparam int unsigned W  = BITWIDTH;
   localparam int unsigned CW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

`ifdef MOD_MULT_RADIX4_EN
   localparam int unsigned STEP = 2;

   // Radix-4 consumes bit pairs, so an odd width cannot be supported.
   if ((BITWIDTH % 2) != 0) begin : g_bad_width
      $error("mod_multiplier: BITWIDTH must be even with MOD_MULT_RADIX4_EN");
   end
`else
   localparam int unsigned STEP = 1;
`endif

   localparam logic [CW-1:0] CNT_START = CW'(W - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(STEP - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  q_q;
   logic [W:0]    p_q;
   logic [CW-1:0] cnt_q;
   logic          valid_q;
   logic          err_q;
   logic [W-1:0]  data_q;

   logic [W:0]    p_d;
   logic          in_err_c;

   // One interleaved step: P' = (2P + bit*A) mod Q, with P, A < Q.
   function automatic logic [W:0] mm_step(input logic [W:0] p,
                                          input logic       mb,
                                          input logic [W:0] a,
                                          input logic [W:0] q);
      logic [W:0] t;
      t = p << 1;
      if (t >= q) t = t - q;
      if (mb) t = t + a;
      if (t >= q) t = t - q;
      return t;
   endfunction

   // Next partial product for the current bit (or bit pair).
`ifdef MOD_MULT_RADIX4_EN
   logic [W:0] p_hi_c;
   always_comb begin
      p_hi_c = mm_step(p_q, b_q[cnt_q], {1'b0, a_q}, {1'b0, q_q});
      p_d    = mm_step(p_hi_c, b_q[cnt_q - CW'(1)], {1'b0, a_q}, {1'b0, q_q});
   end
`else
   always_comb begin
      p_d = mm_step(p_q, b_q[cnt_q], {1'b0, a_q}, {1'b0, q_q});
   end
`endif

   // Range check on the live operands at the accept edge.
   always_comb begin
      in_err_c = (iQ == '0) || (iA >= iQ) || (iB >= iQ);
   end

   // Control FSM and datapath registers.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         q_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (iValid) begin
                  a_q <= iA;
                  b_q <= iB;
                  q_q <= iQ;
                  p_q <= '0;
                  if (in_err_c) begin
                     data_q  <= '0;
                     err_q   <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     cnt_q   <= CNT_START;
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               p_q <= p_d;
               if (cnt_q == CNT_LAST) begin
                  data_q  <= p_d[W-1:0];
                  err_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q - CW'(STEP);
               end
            end
            DONE: begin
               // Error path arrives without valid; raise it one edge later.
               if (!valid_q) begin
                  valid_q <= 1'b1;
               end else if (iReady) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign oReady = (state_q == IDLE);
   assign oValid = valid_q;
   assign oData  = data_q;
   assign oErr   = err_q;

endmodule

// File: tb/tb_mod_multiplier.sv
// Self-checking bench for mod_multiplier against an arithmetic reference.
module tb_mod_multiplier;

   localparam int unsigned W = 32;
`ifdef MOD_MULT_RADIX4_EN
   localparam int LAT = W / 2;
`else
   localparam int LAT = W;
`endif

   logic          clk    = 1'b0;
   logic          iRst   = 1'b1;
   logic          iValid = 1'b0;
   logic          iReady = 1'b0;
   logic [W-1:0]  iA     = '0;
   logic [W-1:0]  iB     = '0;
   logic [W-1:0]  iQ     = '0;
   logic          oReady;
   logic          oValid;
   logic [W-1:0]  oData;
   logic          oErr;

   int total = 0;
   int bad   = 0;

   mod_multiplier #(.BITWIDTH(W)) dut (
      .iClk  (clk),
      .iRst  (iRst),
      .iValid(iValid),
      .oReady(oReady),
      .iA    (iA),
      .iB    (iB),
      .iQ    (iQ),
      .oValid(oValid),
      .iReady(iReady),
      .oData (oData),
      .oErr  (oErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ref_err(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] q);
      return (q == 0) || (a >= q) || (b >= q);
   endfunction

   function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] q);
      logic [63:0] p;
      if (ref_err(a, b, q)) return '0;
      p = 64'(a) * 64'(b);
      return W'(p % 64'(q));
   endfunction

   // Full transaction: accept, measure latency, hold under backpressure, consume.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                         input int hold, input string tag, output logic [W-1:0] res);
      int           lat;
      logic         e;
      logic [W-1:0] exp;
      e   = ref_err(a, b, q);
      exp = ref_res(a, b, q);
      lat = 0;
      while (!oReady && lat < 200) begin
         tick();
         lat++;
      end
      chk({tag, ".rdy"}, 64'(oReady), 1);
      iA = a; iB = b; iQ = q; iValid = 1'b1;
      tick();
      // Scramble inputs after accept; they must not matter now.
      iValid = 1'($urandom_range(0, 1));
      iA = $urandom; iB = $urandom; iQ = $urandom;
      chk({tag, ".busy"}, 64'(oReady), 0);
      lat = 0;
      while (!oValid && lat < 200) begin
         tick();
         lat++;
      end
      chk({tag, ".lat"}, 64'(lat), 64'(e ? 1 : LAT));
      chk({tag, ".data"}, 64'(oData), 64'(exp));
      chk({tag, ".err"}, 64'(oErr), 64'(e));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, ".hold_v"}, 64'(oValid), 1);
         chk({tag, ".hold_d"}, 64'(oData), 64'(exp));
         chk({tag, ".hold_r"}, 64'(oReady), 0);
      end
      res    = oData;
      iValid = 1'b0;
      iReady = 1'b1;
      tick();
      iReady = 1'b0;
      chk({tag, ".cons_v"}, 64'(oValid), 0);
      chk({tag, ".cons_r"}, 64'(oReady), 1);
   endtask

   initial begin
      logic [W-1:0] r;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] acc;
      int           n;
      int           acc_tbl[5] = '{10, 7, 4, 1, 11};

      iRst = 1'b1;
      tick();
      tick();
      iRst = 1'b0;
      chk("rst.valid", 64'(oValid), 0);
      chk("rst.err",   64'(oErr),   0);
      chk("rst.data",  64'(oData),  0);
      chk("rst.ready", 64'(oReady), 1);

      run_op(32'd10, 32'd7, 32'd13, 0, "basic", r);
      run_op(32'd12, 32'd12, 32'd13, 0, "q13max", r);
      run_op(32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFB, 0, "fullw", r);
      run_op(32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF, 1, "qmax", r);
      run_op(32'd13, 32'd2, 32'd13, 0, "a_eq_q", r);
      run_op(32'd0, 32'd0, 32'd0, 0, "q_zero", r);
      run_op(32'd0, 32'd0, 32'd1, 0, "q_one", r);
      run_op(32'd0, 32'd1, 32'd1, 0, "q_one_bad", r);
      run_op(32'd3, 32'd5, 32'd13, 5, "bp", r);

      // Reset in the middle of CALC (counter at 15 in radix-2).
      while (!oReady) tick();
      iA = 32'd10; iB = 32'd7; iQ = 32'd13; iValid = 1'b1;
      tick();
      iValid = 1'b0;
      repeat (LAT / 2) tick();
      iRst = 1'b1;
      tick();
      iRst = 1'b0;
      chk("midrst.valid", 64'(oValid), 0);
      chk("midrst.data",  64'(oData),  0);
      chk("midrst.err",   64'(oErr),   0);
      chk("midrst.ready", 64'(oReady), 1);
      n = 0;
      repeat (LAT + 8) begin
         tick();
         if (oValid) n++;
      end
      chk("midrst.spur", 64'(n), 0);
      run_op(32'd10, 32'd7, 32'd13, 0, "postrst", r);

      // Downstream accumulator modelled here: sum of consumed results mod 13.
      acc = '0;
      for (int i = 0; i < 5; i++) begin
         run_op(32'd10, 32'd1, 32'd13, 0, "accop", r);
         acc = W'((64'(acc) + 64'(r)) % 64'd13);
         chk("acc", 64'(acc), 64'(acc_tbl[i]));
      end

      // Randomized operands across small, full-width and random moduli.
      for (int k = 0; k < 150; k++) begin
         case ($urandom_range(0, 3))
            0:       q = W'($urandom_range(1, 20));
            1:       q = 32'hFFFFFFFF;
            default: q = $urandom;
         endcase
         if (q == 0) begin
            a = 0;
            b = 0;
         end else begin
            a = ($urandom_range(0, 7) == 0) ? $urandom : $urandom % q;
            b = ($urandom_range(0, 7) == 0) ? $urandom : $urandom % q;
         end
         run_op(a, b, q, $urandom_range(0, 3), "rand", r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mod_multiplier.md
Name: mod_multiplier

Overview:
Iterative modular multiplier that computes oData = (iA * iB) mod iQ for operands of up to BITWIDTH bits. It uses MSB-first interleaved shift-add reduction and processes one multiplier bit per cycle. It sits directly upstream of mod_accumulator:
- oData drives the accumulator's iData.
- oValid && iReady drives the accumulator's iEn.
- Together they form a modular multiply-accumulate path for polynomial/NTT kernels.

Parameters:
BITWIDTH, 32, width of operands, modulus and result

Ports:
iClk  input  1  clock, all logic on rising edge
iRst  input  1  synchronous active-high reset
iValid  input  1  operand set valid
oReady  output  1  block can accept operands (high only in IDLE)
iA  input  BITWIDTH  multiplicand, must be < iQ
iB  input  BITWIDTH  multiplier, must be < iQ
iQ  input  BITWIDTH  modulus, must be >= 1
oValid  output  1  result valid, held until consumed
iReady  input  1  downstream accepts result
oData  output  BITWIDTH  product mod Q
oErr  output  1  qualifies oData: operand/modulus out of range

Behaviour:
- Reset (synchronous, iRst high at an edge):
  - state=IDLE; oValid=0; oErr=0; oData=0.
  - Internal A/B/Q/P registers and bit counter are cleared.
  - Reset has priority over every other event, including mid-CALC (the operation is discarded, no oValid) and DONE (the pending result is dropped).
- States: IDLE, CALC, DONE. oReady = (state==IDLE).
- IDLE:
  - On an edge with iValid && oReady, latch iA, iB, iQ and set P=0.
  - Range check on the live inputs: if iQ==0, iA>=iQ or iB>=iQ, go to DONE with oData=0 and oErr=1. oValid then rises 1 edge after the accept edge.
  - Otherwise go to CALC with counter=BITWIDTH-1.
- CALC, one edge per bit i=counter, from BITWIDTH-1 down to 0:
  - T = 2P; if T >= Q then T -= Q.
  - If B[i]: T += A; if T >= Q then T -= Q.
  - P <= T.
  - All intermediates are BITWIDTH+1 bits wide; no overflow is possible given A,B,P < Q <= 2^BITWIDTH-1.
  - When counter==0 has been processed: oData <= T, oErr <= 0, state <= DONE.
  - oValid rises exactly BITWIDTH edges after the accept edge.
- DONE:
  - oValid=1; oData and oErr are held stable while iReady=0 (unbounded backpressure).
  - On an edge with iReady=1: oValid <= 0, state <= IDLE. oData keeps its last value.
  - A new operand set can be accepted no earlier than the edge after the one where the result is consumed. Minimum initiation interval is BITWIDTH+2 cycles.
- iValid in CALC/DONE is ignored; the upstream stage must hold operands until oReady.
- Modulus edge cases:
  - Q=1: only A=B=0 are legal, giving result 0 with oErr=0.
  - Q=2^BITWIDTH-1: full-range operands must be handled exactly.
- Input changes after the accept edge must not affect the result.

Optional Feature:
MOD_MULT_RADIX4_EN
- Defined:
  - CALC processes two multiplier bits per edge (bits i and i-1 chained combinationally through two double/add/reduce steps).
  - Counter steps by 2. BITWIDTH must be even; elaboration error otherwise.
  - Latency from accept to oValid is BITWIDTH/2 edges.
  - Error path, handshake and results are identical.
- Undefined: radix-2 operation as described above, BITWIDTH edges.

Test Plan:
- BITWIDTH=32, Q=13, A=10, B=7 -> oValid exactly 32 edges after accept, oData=5, oErr=0.
- Q=13, A=12, B=12 -> oData=1; then Q=0xFFFFFFFB, A=B=0xFFFFFFFA -> oData=1 (checks the full-width no-overflow path).
- Q=13, A=13, B=2 -> oValid 1 edge after accept, oErr=1, oData=0; then Q=0, A=0, B=0 -> oErr=1.
- Backpressure: Q=13, A=3, B=5 with iReady=0 for 5 cycles after oValid -> oValid and oData=2 stable all 5 cycles; oReady=0 throughout; consumed on the first iReady=1 edge, then oReady=1 next cycle.
- Reset mid-operation: assert iRst for 1 cycle at CALC counter=15 -> next cycle IDLE, oValid=0, oData=0, no spurious result; the following op Q=13, A=10, B=7 still returns 5.
- Chained with mod_accumulator (Q=13, clear at start): five ops A=10, B=1, each result accepted with iReady=1 -> accumulator reads 10, 7, 4, 1, 11.
  - With MOD_MULT_RADIX4_EN defined, rerun the first scenario -> oData=5 exactly 16 edges after accept.
